// File: rtl/ysyx_23060184_imm_pkg.sv
// Shared constants for the NPC immediate generator: extension-op encodings
// and the default datapath width.
package ysyx_23060184_imm_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int EXT_OP_LENGTH = 3;

  // Codes 6 and 7 are deliberately left unassigned; the decoder flags them.
  typedef enum logic [EXT_OP_LENGTH-1:0] {
    EXT_OP_I = 3'd0,
    EXT_OP_U = 3'd1,
    EXT_OP_S = 3'd2,
    EXT_OP_B = 3'd3,
    EXT_OP_J = 3'd4,
    EXT_OP_Z = 3'd5
  } extOp_t;

endpackage

// File: rtl/ysyx_23060184_imm_decode.sv
// Pure-combinational RISC-V immediate decoder (I/S/B/U/J/CSR zimm), shared
// with the single-cycle core.
module ysyx_23060184_imm_decode
  import ysyx_23060184_imm_pkg::*;
#(
  parameter int XLEN = DATA_WIDTH
) (
  input  logic [31:0]              inst,
  input  logic [EXT_OP_LENGTH-1:0] extOp,
  output logic [XLEN-1:0]          imm,
  output logic                     err
);

  logic [31:0] imm32;
  logic        unusedOpcode;

  assign unusedOpcode = ^inst[6:0];

  // Every format is formed as a 32-bit sign-extended value first, so widening
  // to 64 bits is a single replication of bit 31 (zimm has bit 31 clear).
  always_comb begin
    imm32 = '0;
    err   = 1'b0;
    case (extOp)
      EXT_OP_I: imm32 = {{20{inst[31]}}, inst[31:20]};
      EXT_OP_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      EXT_OP_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      EXT_OP_U: imm32 = {inst[31:12], 12'b0};
      EXT_OP_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      EXT_OP_Z: imm32 = {27'b0, inst[19:15]};
      default:  err   = 1'b1;
    endcase
  end

  generate
    if (XLEN > 32) begin : gWide
      assign imm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : gNarrow
      assign imm = imm32;
    end
  endgenerate

endmodule

// File: rtl/ysyx_23060184_imm_queue.sv
// Buffered immediate generator: decodes on push and holds {imm, tag, err}
// in a DEPTH-entry FIFO between decode and execute.
module ysyx_23060184_imm_queue
  import ysyx_23060184_imm_pkg::*;
#(
  parameter int XLEN  = DATA_WIDTH,
  parameter int DEPTH = 4,
  parameter int TAG_W = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [EXT_OP_LENGTH-1:0] in_ext_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_imm,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [XLEN-1:0]  immMem [DEPTH];
  logic [TAG_W-1:0] tagMem [DEPTH];
  logic             errMem [DEPTH];

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;

  logic [XLEN-1:0]  decImm;
  logic             decErr;
  logic             push;
  logic             pop;

  ysyx_23060184_imm_decode #(.XLEN(XLEN)) uDecode (
    .inst  (in_inst),
    .extOp (in_ext_op),
    .imm   (decImm),
    .err   (decErr)
  );

  // No pass-through: a full queue refuses input even while the head drains.
  assign in_ready  = (count != FULL_COUNT) && !flush;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  assign out_imm = out_valid ? immMem[rdPtr] : '0;
  assign out_tag = out_valid ? tagMem[rdPtr] : '0;
  assign out_err = out_valid ? errMem[rdPtr] : 1'b0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      immMem[wrPtr] <= decImm;
      tagMem[wrPtr] <= in_tag;
      errMem[wrPtr] <= decErr;
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_imm_queue.sv
// Directed self-checking bench for the immediate queue at XLEN=32 (DEPTH=4)
// plus a second XLEN=64 instance for the wide sign/zero extension cases.
module tb_ysyx_23060184_imm_queue;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [2:0]  in_ext_op;
  logic [31:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [31:0] out_tag;
  logic        out_err;

  logic        d64Valid;
  logic        d64InReady;
  logic [31:0] d64Inst;
  logic [2:0]  d64Op;
  logic [31:0] d64Tag;
  logic        d64OutValid;
  logic        d64OutReady;
  logic [63:0] d64OutImm;
  logic [31:0] d64OutTag;
  logic        d64OutErr;
  logic        d64Flush;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_23060184_imm_queue #(.XLEN(32), .DEPTH(4), .TAG_W(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_ext_op (in_ext_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  ysyx_23060184_imm_queue #(.XLEN(64), .DEPTH(4), .TAG_W(32)) dut64 (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (d64Flush),
    .in_valid  (d64Valid),
    .in_ready  (d64InReady),
    .in_inst   (d64Inst),
    .in_ext_op (d64Op),
    .in_tag    (d64Tag),
    .out_valid (d64OutValid),
    .out_ready (d64OutReady),
    .out_imm   (d64OutImm),
    .out_tag   (d64OutTag),
    .out_err   (d64OutErr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_ext_op = '0;
    in_tag = '0; out_ready = 1'b0;
    d64Valid = 1'b0; d64Inst = '0; d64Op = '0; d64Tag = '0; d64OutReady = 1'b1; d64Flush = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if ({out_imm, out_tag, out_err} !== 65'd0) begin failures++; $display("FAIL reset_outputs: imm=%h tag=%h err=%b want zeros", out_imm, out_tag, out_err); end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_formats();
    logic [31:0] insts [6] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000EE3, 32'h123450B7, 32'h001000EF, 32'h000F8073};
    logic [2:0]  ops   [6] = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd4, 3'd5};
    logic [31:0] exps  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000, 32'h00000800, 32'h0000001F};
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_inst = insts[k]; in_ext_op = ops[k]; in_tag = 32'h100 + k;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fmt_in_ready[%0d]: got %b want 1", k, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fmt_valid[%0d]: got %b want 1", k, out_valid); end
      checks++; if (out_imm !== exps[k]) begin failures++; $display("FAIL fmt_imm[%0d]: got %h want %h", k, out_imm, exps[k]); end
      checks++; if (out_tag !== 32'h100 + k) begin failures++; $display("FAIL fmt_tag[%0d]: got %h want %h", k, out_tag, 32'h100 + k); end
      checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL fmt_err[%0d]: got %b want 0", k, out_err); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fmt_drained: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_xlen64();
    d64Valid = 1'b1; d64Inst = 32'h800000B7; d64Op = 3'd1; d64Tag = 32'hA;
    tick();
    checks++; if (d64OutImm !== 64'hFFFFFFFF80000000) begin failures++; $display("FAIL x64_u: got %h want ffffffff80000000", d64OutImm); end
    d64Inst = 32'h000F8073; d64Op = 3'd5; d64Tag = 32'hB;
    tick();
    checks++; if (d64OutImm !== 64'h000000000000001F) begin failures++; $display("FAIL x64_z: got %h want 000000000000001f", d64OutImm); end
    checks++; if (d64OutTag !== 32'hB || d64OutValid !== 1'b1) begin failures++; $display("FAIL x64_tag: tag=%h valid=%b want b/1", d64OutTag, d64OutValid); end
    d64Valid = 1'b0;
    tick();
  endtask

  task automatic test_fill_backpressure();
    out_ready = 1'b0;
    in_inst = 32'h00100093; in_ext_op = 3'd0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_tag = k;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d]: got %b want 1", k, in_ready); end
      tick();
    end
    in_tag = 32'd99;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_full: in_ready=%b want 0", in_ready); end
    checks++; if (out_tag !== 32'd0) begin failures++; $display("FAIL drain_tag[0]: got %0d want 0", out_tag); end
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL drain_ready_back: got %b want 1", in_ready); end
    for (int k = 1; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1 || out_tag !== k) begin failures++; $display("FAIL drain_tag[%0d]: valid=%b tag=%0d want 1/%0d", k, out_valid, out_tag, k); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty: out_valid=%b want 0 (beat 99 must be refused)", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] order [6] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
    out_ready = 1'b0;
    in_inst = 32'h00100093; in_ext_op = 3'd0; in_valid = 1'b1;
    in_tag = order[0]; tick();
    in_tag = order[1]; tick();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 4); in_tag = order[(k + 2) % 6];
      #1;
      checks++; if (out_valid !== 1'b1 || out_tag !== order[k]) begin failures++; $display("FAIL b2b_tag[%0d]: valid=%b tag=%h want 1/%h", k, out_valid, out_tag, order[k]); end
      if (k < 4) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, in_ready); end
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_count: out_valid=%b want 0 after 6 pops", out_valid); end
  endtask

  task automatic test_illegal_op();
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'hFFFFFFFF; in_ext_op = 3'd7; in_tag = 32'h77;
    tick();
    checks++; if (out_valid !== 1'b1 || out_imm !== 32'd0 || out_err !== 1'b1) begin failures++; $display("FAIL illegal: valid=%b imm=%h err=%b want 1/0/1", out_valid, out_imm, out_err); end
    in_inst = 32'h00100093; in_ext_op = 3'd0; in_tag = 32'h78;
    tick();
    checks++; if (out_err !== 1'b0 || out_imm !== 32'd1) begin failures++; $display("FAIL after_illegal: imm=%h err=%b want 1/0", out_imm, out_err); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_ext_op = 3'd0;
    for (int k = 0; k < 3; k++) begin in_tag = k; tick(); end
    in_tag = 32'h55; flush = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_pre_valid: got %b want 1", out_valid); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_cleared: out_valid=%b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_ext_op = 3'd0; in_tag = 32'h33;
    tick(); tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL arst_pre: out_valid=%b want 1", out_valid); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid: got %b want 0 before edge", out_valid); end
    checks++; if ({out_imm, out_tag, out_err} !== 65'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL arst_outputs: imm=%h tag=%h err=%b ready=%b", out_imm, out_tag, out_err, in_ready); end
    tick();
    rstn = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_after: out_valid=%b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_xlen64();
    test_fill_backpressure();
    test_back_to_back();
    test_illegal_op();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
